sram_like_dmem_responder: RTL and testbench
===========================================

# sram_like_dmem_responder

Responder (slave) end of the core's sram-like data-memory interface. It accepts one request at a time from the MEM-stage initiator, holds it for a programmable latency, then commits the write or returns read data with a single-cycle `data_ok` pulse. It is the memory model for core-level simulation and the template for the data-side AXI bridge front end.

## Interface
Parameters:
- `ADDR_W`, 10, word-address bits; the array holds 2^ADDR_W 32-bit words.
- `LATENCY`, 2, cycles from the address handshake to `data_ok`; legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `req`  in  1  initiator request valid.
- `wr`  in  1  1 = write, 0 = read; sampled with `req`.
- `size`  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved.
- `addr`  in  32  byte address.
- `wdata`  in  32  write data, byte lanes aligned to `addr[1:0]`.
- `addr_ok`  out  1  request accepted this cycle when `req` is also high.
- `data_ok`  out  1  one-cycle completion pulse.
- `rdata`  out  32  read word; valid only while `data_ok`=1.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: `addr_ok`=1. On `req`=1, latch `wr`, `size`, `addr`, `wdata`. Go to RESP if LATENCY=1, else to WAIT with counter=LATENCY-2.
  - WAIT: `addr_ok`=0. Decrement the counter. Go to RESP when counter=0.
  - RESP: `data_ok`=1, `addr_ok`=0. Return to IDLE unconditionally.
- `addr_ok` is combinational (state==IDLE). `data_ok` is combinational (state==RESP). Neither depends on `req` in the same cycle.
- Word index is latched `addr[ADDR_W+1:2]`. Higher address bits are ignored, so addresses alias modulo 2^(ADDR_W+2).
- Byte strobes from latched `size` and `addr[1:0]`:
  - byte: 1 << a
  - half: a[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
  - reserved: 4'b0000
- Misalignment is not checked. `addr[0]` is ignored for halfwords and `addr[1:0]` is ignored for words.
- Write commit: on the clock edge that leaves RESP, the strobed byte lanes of `wdata` are written into the array.
- Read: `rdata` is the full 32-bit word `mem[index]` during RESP. The initiator performs lane extraction and sign extension. The registered copy of `rdata` holds its value outside RESP.
- At most one transaction is outstanding. A read always observes every earlier completed write.
- The memory array is not reset. Contents are X until written.

## Timing
- Handshake edge: the rising edge with `req`=1 and `addr_ok`=1, called edge k.
- `data_ok` is high in the cycle after edge k+LATENCY-1, i.e. exactly LATENCY cycles after acceptance.
- `data_ok` is never high for two consecutive cycles.
- The next `addr_ok` comes in the cycle after RESP. Peak throughput is one transaction per LATENCY+1 cycles.
- `req` held high continuously: a new request is accepted in every IDLE cycle.
- `req` dropped while in WAIT or RESP: no effect. The latched request still completes.
- Reset values (on `rst` low, asynchronous): state=IDLE, counter=0, `addr_ok`=1, `data_ok`=0, `rdata`=0.
- Reset during WAIT: the transaction is abandoned, no write is committed, and no `data_ok` is issued.
- Reset asserted in RESP: the write is committed only if the clock edge leaving RESP precedes the reset assertion.

## Test plan
- **Word write then read, LATENCY=2:** write `addr`=0x100, `wdata`=0xDEADBEEF, `size`=2. Then read 0x100. Require:
  - `data_ok` exactly 2 cycles after each handshake.
  - `rdata`=0xDEADBEEF on the read's `data_ok`.
  - `addr_ok`=0 for 2 cycles per transaction.
- **Byte/half merge:** word-write 0x11223344 to 0x20, byte-write `wdata`=0x0000AA00 to 0x21, half-write `wdata`=0xBBBB0000 to 0x22. Read 0x20 -> 0xBBBBAA44.
- **Reserved size:** write 0x20 with `size`=3 and `wdata`=0xFFFFFFFF. Still get `data_ok`. Read 0x20 -> unchanged value.
- **Back-to-back with LATENCY=1:** hold `req`=1 for 4 reads. Require:
  - `addr_ok`/`data_ok` alternate every cycle.
  - 4 `data_ok` pulses in 8 cycles, never 2 consecutive.
- **Aliasing, ADDR_W=10:** write 0xCAFEF00D to 0x00001004. Read 0x00000004 -> 0xCAFEF00D.
- **Reset mid-WAIT (LATENCY=3):** accept a write of 0x12345678 to 0x40, pull `rst` low one cycle later. Require:
  - `addr_ok`=1 and `data_ok`=0 immediately.
  - A subsequent read of 0x40 returns the pre-write value.

Source files
------------

// File: rtl/sram_like_dmem_responder.sv
// Responder end of the sram-like data-memory interface.
// Takes one request at a time, holds it for LATENCY cycles, then commits
// the write or returns the read word with a single-cycle data_ok pulse.
module sram_like_dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;
  // WAIT runs for LATENCY-1 cycles; the counter counts down to zero inside it.
  // For LATENCY=1 the value is never used because WAIT is skipped.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic              w_accept;

  // Request captured at the address handshake.
  logic              r_wr;
  logic [1:0]        r_size;
  logic [1:0]        r_boff;
  logic [ADDR_W-1:0] r_idx;
  logic [31:0]       r_wdata;

  logic [31:0]       r_rdata;
  logic [31:0]       r_mem [DEPTH];
  logic [31:0]       w_rword;
  logic [3:0]        w_strb;

  // Address bits above the array are deliberately dropped (aliasing).
  logic              w_unused_addr;
  assign w_unused_addr = ^addr[31:ADDR_W+2];

  // Handshake flags depend on state only, never on req.
  assign addr_ok = (r_state == S_IDLE);
  assign data_ok = (r_state == S_RESP);

  // State and wait-counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, one RESP cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = S_RESP;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture the request on the handshake edge; inputs are ignored afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_boff  <= 2'd0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_wr    <= wr;
      r_size  <= size;
      r_boff  <= addr[1:0];
      r_idx   <= addr[ADDR_W+1:2];
      r_wdata <= wdata;
    end
  end

  // Byte strobes from the latched size and byte offset; misalignment ignored.
  always_comb begin
    w_strb = 4'b0000;
    case (r_size)
      2'd0:    w_strb = 4'b0001 << r_boff;
      2'd1:    w_strb = r_boff[1] ? 4'b1100 : 4'b0011;
      2'd2:    w_strb = 4'b1111;
      default: w_strb = 4'b0000;
    endcase
  end

  // Array write on the edge leaving RESP. No reset: an async reset that
  // lands before that edge pulls the state out of RESP and cancels the write.
  always_ff @(posedge clk) begin
    if (r_state == S_RESP && r_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  assign w_rword = r_mem[r_idx];

  // Keep a copy of the last returned word so rdata is stable outside RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  r_rdata <= 32'd0;
    else if (r_state == S_RESP) r_rdata <= w_rword;
  end

  assign rdata = (r_state == S_RESP) ? w_rword : r_rdata;

endmodule

// File: tb/tb_sram_like_dmem_responder.sv
// Randomized bench for sram_like_dmem_responder: three instances at
// LATENCY 1, 2, 3 checked against a word-array reference model.
module tb_sram_like_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_a   [3];
  logic        req_a   [3];
  logic        wr_a    [3];
  logic [1:0]  size_a  [3];
  logic [31:0] addr_a  [3];
  logic [31:0] wdata_a [3];
  logic        aok_a   [3];
  logic        dok_a   [3];
  logic [31:0] rdata_a [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sram_like_dmem_responder #(.ADDR_W(10), .LATENCY(g + 1)) u_dut (
      .clk    (clk),
      .rst    (rst_a[g]),
      .req    (req_a[g]),
      .wr     (wr_a[g]),
      .size   (size_a[g]),
      .addr   (addr_a[g]),
      .wdata  (wdata_a[g]),
      .addr_ok(aok_a[g]),
      .data_ok(dok_a[g]),
      .rdata  (rdata_a[g])
    );
  end

  // Reference: one word array per instance, updated when a write completes.
  bit [31:0] mdl [3][1024];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'h3FF);
  endfunction

  function automatic void mdl_wr(input int d, input logic [1:0] sz,
                                 input logic [31:0] a, input logic [31:0] wd);
    int idx;
    int off;
    bit en;
    idx = widx(a);
    off = int'(a & 32'h3);
    for (int b = 0; b < 4; b++) begin
      case (sz)
        2'd0:    en = (b == off);
        2'd1:    en = ((b / 2) == (off / 2));
        2'd2:    en = 1'b1;
        default: en = 1'b0;
      endcase
      if (en) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
    end
  endfunction

  // One complete transaction on instance d with handshake/latency checks.
  task automatic xact(input int d, input logic w, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd);
    int    n;
    int    lat;
    string t;
    logic [31:0] exp_rd;
    lat = d + 1;
    rd  = 32'd0;
    t   = $sformatf("L%0d %s a=%h sz=%0d", lat, w ? "wr" : "rd", a, sz);
    exp_rd = mdl[d][widx(a)];
    @(negedge clk);
    req_a[d] = 1'b1; wr_a[d] = w; size_a[d] = sz; addr_a[d] = a; wdata_a[d] = wd;
    n = 0;
    while (aok_a[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({t, " addr_ok"}, {31'd0, aok_a[d]}, 32'd1);
    @(posedge clk);
    #1;
    // Scramble the bus after the handshake: the latched request must win.
    req_a[d] = 1'b0; wr_a[d] = 1'($urandom); size_a[d] = 2'($urandom);
    addr_a[d] = $urandom; wdata_a[d] = $urandom;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      chk({t, " busy addr_ok"}, {31'd0, aok_a[d]}, 32'd0);
      if (dok_a[d] === 1'b1) break;
    end
    chk({t, " latency"}, n, lat);
    if (w) begin
      mdl_wr(d, sz, a, wd);
    end else begin
      rd = rdata_a[d];
      chk({t, " rdata"}, rd, exp_rd);
    end
    @(negedge clk);
    chk({t, " data_ok single"}, {31'd0, dok_a[d]}, 32'd0);
    chk({t, " addr_ok back"}, {31'd0, aok_a[d]}, 32'd1);
    if (!w) chk({t, " rdata hold"}, rdata_a[d], exp_rd);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] pre;
    logic [31:0] a;
    int          k;
    int          pulses;

    for (int d = 0; d < 3; d++) begin
      rst_a[d] = 1'b0; req_a[d] = 1'b0; wr_a[d] = 1'b0;
      size_a[d] = 2'd0; addr_a[d] = 32'd0; wdata_a[d] = 32'd0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset L%0d addr_ok", d + 1), {31'd0, aok_a[d]}, 32'd1);
      chk($sformatf("reset L%0d data_ok", d + 1), {31'd0, dok_a[d]}, 32'd0);
      chk($sformatf("reset L%0d rdata", d + 1), rdata_a[d], 32'd0);
      rst_a[d] = 1'b1;
    end

    // Give every word the random traffic and directed tests touch a value.
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 16; i++) xact(d, 1'b1, 2'd2, 32'(i) << 2, $urandom, rd);
      xact(d, 1'b1, 2'd2, 32'h40,  $urandom, rd);
      xact(d, 1'b1, 2'd2, 32'h100, $urandom, rd);
    end

    // Directed, LATENCY=2.
    xact(1, 1'b1, 2'd2, 32'h100, 32'hDEADBEEF, rd);
    xact(1, 1'b0, 2'd2, 32'h100, 32'h0, rd);
    chk("word wr/rd", rd, 32'hDEADBEEF);
    xact(1, 1'b1, 2'd2, 32'h20, 32'h11223344, rd);
    xact(1, 1'b1, 2'd0, 32'h21, 32'h0000AA00, rd);
    xact(1, 1'b1, 2'd1, 32'h22, 32'hBBBB0000, rd);
    xact(1, 1'b0, 2'd2, 32'h20, 32'h0, rd);
    chk("byte/half merge", rd, 32'hBBBBAA44);
    xact(1, 1'b1, 2'd3, 32'h20, 32'hFFFFFFFF, rd);
    xact(1, 1'b0, 2'd2, 32'h20, 32'h0, rd);
    chk("reserved size", rd, 32'hBBBBAA44);
    xact(1, 1'b1, 2'd2, 32'h00001004, 32'hCAFEF00D, rd);
    xact(1, 1'b0, 2'd2, 32'h00000004, 32'h0, rd);
    chk("alias", rd, 32'hCAFEF00D);

    // Back-to-back reads with req held high, LATENCY=1.
    @(negedge clk);
    req_a[0] = 1'b1; wr_a[0] = 1'b0; size_a[0] = 2'd2; addr_a[0] = 32'h0;
    k = 0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("b2b addr_ok c%0d", i), {31'd0, aok_a[0]}, 32'(i % 2 == 0));
      chk($sformatf("b2b data_ok c%0d", i), {31'd0, dok_a[0]}, 32'(i % 2));
      if (dok_a[0] === 1'b1) begin
        chk($sformatf("b2b rdata %0d", k), rdata_a[0], mdl[0][k]);
        pulses++;
        k++;
        addr_a[0] = 32'(k) << 2;
      end
    end
    req_a[0] = 1'b0;
    chk("b2b pulses", pulses, 4);

    // Reset while in WAIT, LATENCY=3: the write must be dropped.
    pre = mdl[2][widx(32'h40)];
    @(negedge clk);
    req_a[2] = 1'b1; wr_a[2] = 1'b1; size_a[2] = 2'd2;
    addr_a[2] = 32'h40; wdata_a[2] = 32'h12345678;
    chk("rstwait accept", {31'd0, aok_a[2]}, 32'd1);
    @(posedge clk);
    #1;
    req_a[2] = 1'b0;
    @(negedge clk);
    chk("rstwait in WAIT", {31'd0, aok_a[2]}, 32'd0);
    rst_a[2] = 1'b0;
    #1;
    chk("rstwait addr_ok", {31'd0, aok_a[2]}, 32'd1);
    chk("rstwait data_ok", {31'd0, dok_a[2]}, 32'd0);
    chk("rstwait rdata", rdata_a[2], 32'd0);
    @(negedge clk);
    chk("rstwait hold data_ok", {31'd0, dok_a[2]}, 32'd0);
    rst_a[2] = 1'b1;
    xact(2, 1'b0, 2'd2, 32'h40, 32'h0, rd);
    chk("rstwait no commit", rd, pre);

    // Random mixed traffic over 16 words with random high (aliased) bits.
    for (int i = 0; i < 180; i++) begin
      int d;
      d = i % 3;
      a = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 15)) << 2)
          | 32'($urandom_range(0, 3));
      xact(d, 1'($urandom), 2'($urandom), a, $urandom, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
